// File: rtl/led_flash_arbiter.sv
// Shares one flashing LED between NREQ requesters: grant one, blink its count, pulse done.
// Define LED_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module led_flash_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4,
  parameter int HALF  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] cnt,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  led
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic             led_q, led_d;
  logic [PTR_W-1:0] sel_idx;

  logic [CNT_W-1:0] cnt_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_unpack
    assign cnt_arr[gi] = cnt[gi*CNT_W +: CNT_W];
  end

`ifdef LED_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) sel_idx = PTR_W'(k);
    end
  end
`else
  localparam logic [PTR_W:0] NREQ_EXT = (PTR_W + 1)'(NREQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [PTR_W:0]   scan_pos;

  // Scan from the far end back toward the pointer so the closest set bit wins.
  always_comb begin
    sel_idx  = '0;
    scan_pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_pos = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (scan_pos >= NREQ_EXT) scan_pos = scan_pos - NREQ_EXT;
      if (req[scan_pos[PTR_W-1:0]]) sel_idx = scan_pos[PTR_W-1:0];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    grant_d = grant_q;
`ifndef LED_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
    win_d   = win_q;
`endif
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|req) begin
          rem_d            = cnt_arr[sel_idx];
          grant_d[sel_idx] = 1'b1;
          phase_d          = '0;
          state_d          = (cnt_arr[sel_idx] != '0) ? S_ON : S_DONE;
`ifndef LED_ARB_FIXED_PRIO_EN
          win_d            = sel_idx;
`endif
        end
      end
      S_ON: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = S_OFF;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_OFF: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          // remaining is always >= 1 here; the guard keeps it from ever wrapping
          rem_d   = (rem_q != '0) ? rem_q - 1'b1 : '0;
          state_d = (rem_q <= CNT_W'(1)) ? S_DONE : S_ON;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
`ifndef LED_ARB_FIXED_PRIO_EN
        ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered off the next state so the LED pin never glitches.
  always_comb begin
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) ? grant_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      phase_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
`ifndef LED_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
      win_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
`ifndef LED_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
      win_q   <= win_d;
`endif
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_flash_arbiter.sv
// Randomized self-checking bench for led_flash_arbiter; expectations come from a
// transaction-level model (winner choice + blink waveform arithmetic).
module tb_led_flash_arbiter;

  localparam int NREQ  = 4;
  localparam int CNT_W = 4;
  localparam int HALF  = 4;
  localparam int VW    = 2*NREQ + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] cnt;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  led;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_ptr  = 0;
  logic [VW-1:0] obs [256];

  led_flash_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .HALF(HALF)) dut (
    .clk(clk), .rst(rst), .req(req), .cnt(cnt),
    .grant(grant), .done(done), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  // Winner according to the arbitration rule, -1 if nothing requested.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int i;
`ifdef LED_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) begin
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Expected {grant, done, busy, led} at cycle t after the granting edge.
  function automatic logic [VW-1:0] exp_vec(input int win, input int n, input int t);
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] d;
    logic            l;
    int              len;
    oh = '0;
    oh[win] = 1'b1;
    len = 2*HALF*n + 1;
    if (t >= len) return '0;
    d = (t == len - 1) ? oh : {NREQ{1'b0}};
    l = (t < len - 1) && ((t % (2*HALF)) < HALF);
    return {oh, d, 1'b1, l};
  endfunction

  function automatic int cnt_of(input int win);
    return int'(cnt[win*CNT_W +: CNT_W]);
  endfunction

  // Records outputs #1 after each edge; optionally scrambles req/cnt or pulses reset.
  task automatic capture(input int ncyc, input int drop_t, input int rst_t);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      obs[c] = {grant, done, busy, led};
      if (c == drop_t) begin
        req = NREQ'($urandom);
        cnt = (NREQ*CNT_W)'($urandom);
      end
      if (rst_t >= 0 && c == rst_t) rst = 1'b0;
      if (rst_t >= 0 && c == rst_t + 2) rst = 1'b1;
    end
  endtask

  task automatic test_reset();
    int win, n;
    rst = 1'b0;
    req = '1;
    for (int i = 0; i < NREQ; i++) cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(1, 3));
    capture(3, -1, -1);
    for (int t = 0; t < 3; t++) begin
      n_tests++;
      if (obs[t] !== '0) begin
        n_fail++;
        $display("FAIL reset t=%0d got=%b expected=%b", t, obs[t], {VW{1'b0}});
      end
    end
    rst = 1'b1;
    rr_ptr = 0;
    win = pick(req, rr_ptr);
    n = cnt_of(win);
    capture(2*HALF*n + 2, -1, -1);
    for (int t = 0; t < 2*HALF*n + 2; t++) begin
      n_tests++;
      if (obs[t] !== exp_vec(win, n, t)) begin
        n_fail++;
        $display("FAIL reset_first_grant t=%0d got=%b expected=%b", t, obs[t], exp_vec(win, n, t));
      end
    end
    rr_ptr = (win + 1) % NREQ;
    $display("[TB] reset: first grant to requester %0d, count %0d", win, n);
  endtask

  task automatic test_single_burst();
    int win, n;
    req = 4'b0001;
    cnt = (NREQ*CNT_W)'($urandom);
    cnt[0 +: CNT_W] = CNT_W'(2);
    win = pick(req, rr_ptr);
    n = cnt_of(win);
    capture(2*HALF*n + 2, -1, -1);
    for (int t = 0; t < 2*HALF*n + 2; t++) begin
      n_tests++;
      if (obs[t] !== exp_vec(win, n, t)) begin
        n_fail++;
        $display("FAIL single_burst t=%0d got=%b expected=%b", t, obs[t], exp_vec(win, n, t));
      end
    end
    rr_ptr = (win + 1) % NREQ;
    $display("[TB] single burst: requester %0d, count %0d", win, n);
    // Largest representable count must not wrap.
    req = 4'b1000;
    cnt[3*CNT_W +: CNT_W] = '1;
    win = pick(req, rr_ptr);
    n = cnt_of(win);
    capture(2*HALF*n + 2, -1, -1);
    for (int t = 0; t < 2*HALF*n + 2; t++) begin
      n_tests++;
      if (obs[t] !== exp_vec(win, n, t)) begin
        n_fail++;
        $display("FAIL max_count t=%0d got=%b expected=%b", t, obs[t], exp_vec(win, n, t));
      end
    end
    rr_ptr = (win + 1) % NREQ;
    $display("[TB] max count burst: requester %0d, count %0d", win, n);
  endtask

  task automatic test_round_robin();
    int win, n;
    req = '1;
    for (int i = 0; i < NREQ; i++) cnt[i*CNT_W +: CNT_W] = CNT_W'(1);
    for (int s = 0; s < NREQ + 1; s++) begin
      win = pick(req, rr_ptr);
      n = cnt_of(win);
      capture(2*HALF*n + 2, -1, -1);
      for (int t = 0; t < 2*HALF*n + 2; t++) begin
        n_tests++;
        if (obs[t] !== exp_vec(win, n, t)) begin
          n_fail++;
          $display("FAIL round_robin s=%0d t=%0d got=%b expected=%b", s, t, obs[t], exp_vec(win, n, t));
        end
      end
      rr_ptr = (win + 1) % NREQ;
      $display("[TB] round robin service %0d: requester %0d", s, win);
    end
  endtask

  task automatic test_zero_count();
    int win;
    req = 4'b0100;
    cnt = (NREQ*CNT_W)'($urandom);
    cnt[2*CNT_W +: CNT_W] = '0;
    win = pick(req, rr_ptr);
    capture(2, -1, -1);
    for (int t = 0; t < 2; t++) begin
      n_tests++;
      if (obs[t] !== exp_vec(win, 0, t)) begin
        n_fail++;
        $display("FAIL zero_count t=%0d got=%b expected=%b", t, obs[t], exp_vec(win, 0, t));
      end
    end
    rr_ptr = (win + 1) % NREQ;
    $display("[TB] zero count: requester %0d", win);
  endtask

  task automatic test_mid_service();
    int win, n;
    req = 4'b0010;
    cnt = (NREQ*CNT_W)'($urandom);
    cnt[1*CNT_W +: CNT_W] = CNT_W'(3);
    win = pick(req, rr_ptr);
    n = cnt_of(win);
    capture(2*HALF*n + 2, 5, -1);
    for (int t = 0; t < 2*HALF*n + 2; t++) begin
      n_tests++;
      if (obs[t] !== exp_vec(win, n, t)) begin
        n_fail++;
        $display("FAIL mid_service_drop t=%0d got=%b expected=%b", t, obs[t], exp_vec(win, n, t));
      end
    end
    rr_ptr = (win + 1) % NREQ;
    $display("[TB] mid-service req/cnt change: requester %0d, count %0d", win, n);
    // Reset in the middle of an ON phase abandons the service with no done.
    req = 4'b0010;
    cnt[1*CNT_W +: CNT_W] = CNT_W'(3);
    win = pick(req, rr_ptr);
    n = cnt_of(win);
    capture(5, -1, 2);
    for (int t = 0; t < 5; t++) begin
      n_tests++;
      if (t <= 2 && obs[t] !== exp_vec(win, n, t)) begin
        n_fail++;
        $display("FAIL reset_mid_on t=%0d got=%b expected=%b", t, obs[t], exp_vec(win, n, t));
      end else if (t > 2 && obs[t] !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_on t=%0d got=%b expected=%b", t, obs[t], {VW{1'b0}});
      end
    end
    rr_ptr = 0;
    req = '1;
    for (int i = 0; i < NREQ; i++) cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 2));
    win = pick(req, rr_ptr);
    n = cnt_of(win);
    capture(2*HALF*n + 2, -1, -1);
    for (int t = 0; t < 2*HALF*n + 2; t++) begin
      n_tests++;
      if (obs[t] !== exp_vec(win, n, t)) begin
        n_fail++;
        $display("FAIL pointer_after_reset t=%0d got=%b expected=%b", t, obs[t], exp_vec(win, n, t));
      end
    end
    rr_ptr = (win + 1) % NREQ;
    $display("[TB] after mid-service reset: requester %0d, count %0d", win, n);
  endtask

  task automatic test_random();
    int win, n, len, drop_t;
    for (int it = 0; it < 24; it++) begin
      req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) cnt[i*CNT_W +: CNT_W] = '1;
        else cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
      end
      if (req == '0) begin
        capture(2, -1, -1);
        for (int t = 0; t < 2; t++) begin
          n_tests++;
          if (obs[t] !== '0) begin
            n_fail++;
            $display("FAIL random_idle it=%0d t=%0d got=%b expected=%b", it, t, obs[t], {VW{1'b0}});
          end
        end
        $display("[TB] random %0d: no request, idle", it);
      end else begin
        win = pick(req, rr_ptr);
        n = cnt_of(win);
        len = 2*HALF*n + 1;
        drop_t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
        capture(len + 1, drop_t, -1);
        for (int t = 0; t < len + 1; t++) begin
          n_tests++;
          if (obs[t] !== exp_vec(win, n, t)) begin
            n_fail++;
            $display("FAIL random it=%0d t=%0d got=%b expected=%b", it, t, obs[t], exp_vec(win, n, t));
          end
        end
        rr_ptr = (win + 1) % NREQ;
        $display("[TB] random %0d: req=%b winner %0d count %0d", it, req, win, n);
      end
    end
  endtask

`ifdef LED_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int n;
    req = 4'b0011;
    for (int i = 0; i < NREQ; i++) cnt[i*CNT_W +: CNT_W] = CNT_W'(1);
    for (int s = 0; s < 4; s++) begin
      n = cnt_of(0);
      capture(2*HALF*n + 2, -1, -1);
      for (int t = 0; t < 2*HALF*n + 2; t++) begin
        n_tests++;
        if (obs[t] !== exp_vec(0, n, t)) begin
          n_fail++;
          $display("FAIL fixed_prio s=%0d t=%0d got=%b expected=%b", s, t, obs[t], exp_vec(0, n, t));
        end
      end
      $display("[TB] fixed priority service %0d: requester 0", s);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    req = '0;
    cnt = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_zero_count();
    test_mid_service();
    test_random();
`ifdef LED_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
